branch_predict_ctrl: RTL and testbench

- Fetch-side branch prediction and misprediction-recovery controller for the 5-stage RV32I pipeline.
- Predicts in IF using a direct-mapped, tagged BTB with a 2-bit saturating counter per entry.
- Resolves in EX against the taken/not-taken decision from the EX-stage branch comparator, then drives the redirect PC and the IF/ID and ID/EX flushes.
- Trains the table and keeps branch/mispredict statistics.

---
 rtl/branch_predict_ctrl_pkg.sv | 35 +++
 rtl/branch_predict_ctrl_sat_counter2.sv | 25 ++
 rtl/branch_predict_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Counter encodings, branch-type codes and the redirect payload.
package branch_predict_ctrl_pkg;

  localparam int unsigned BTB_IDX_W = 6;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  // Decoder branch types; upstream forms BranchValidE from type != BR_NOBRANCH
  typedef enum logic [2:0] {
    BR_NOBRANCH = 3'd0,
    BR_BEQ      = 3'd1,
    BR_BNE      = 3'd2,
    BR_BLT      = 3'd3,
    BR_BGE      = 3'd4,
    BR_BLTU     = 3'd5,
    BR_BGEU     = 3'd6
  } br_type_e;

  typedef struct packed {
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
  } bp_redirect_t;

  function automatic logic is_cond_branch(input br_type_e t);
    return t != BR_NOBRANCH;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// 2-bit saturating up/down counter next-value logic with load.
// Shared across all BTB entries on the single training write path.
module sat_counter2
  import branch_predict_ctrl_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  output logic [1:0] cnt_next_c
);

  always_comb begin
    cnt_next_c = cnt_i;
    if (load_i) begin
      cnt_next_c = load_val_i;
    end else if (inc_i && (cnt_i != ST)) begin
      cnt_next_c = cnt_i + 2'd1;
    end else if (dec_i && (cnt_i != SNT)) begin
      cnt_next_c = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped tagged BTB predictor with EX-stage resolve, redirect/flush
// generation, table training and branch/mispredict statistics.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W    = BTB_IDX_W,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchValidE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0]                valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]     tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]      target_q;
  logic [ENTRIES-1:0][1:0]           cnt_q;
  logic [XLEN-1:0]                   branch_cnt_q, branch_cnt_d;
  logic [XLEN-1:0]                   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;

  logic             wr_en;
  logic [XLEN-1:0]  target_d;
  logic [1:0]       cnt_d;
  logic             cnt_inc, cnt_dec, cnt_load;
  bp_redirect_t     redir;

  logic             unused_pc_lsb;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = ^{PCF[1:0], PCE[1:0]};

  // IF-side lookup reads registered state only, so same-index training is not bypassed
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && cnt_q[idx_f][1];
    PredTargetF = target_q[idx_f];
  end

  // Resolve: everything derived from BranchE/BrTargetE is masked when no branch is in EX
  always_comb begin
    redir = '0;
    if (BranchValidE) begin
      redir.mispredict  = (BranchE != PredTakenE) ||
                          (BranchE && PredTakenE && (PredTargetE != BrTargetE));
      redir.redirect_pc = BranchE ? BrTargetE : (PCE + 32'd4);
    end
  end

  assign MispredictE = redir.mispredict;
  assign RedirectPCE = redir.redirect_pc;
  assign FlushD      = redir.mispredict;
  assign FlushE      = redir.mispredict;

  always_comb begin
    hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    cnt_inc  = BranchValidE && hit_e && BranchE;
    cnt_dec  = BranchValidE && hit_e && !BranchE;
    cnt_load = BranchValidE && !hit_e && BranchE;
    wr_en    = cnt_inc || cnt_dec || cnt_load;
    target_d = target_q[idx_e];
    if (BranchValidE && BranchE) begin
      target_d = BrTargetE;
    end
    branch_cnt_d  = branch_cnt_q + XLEN'(BranchValidE);
    mispred_cnt_d = mispred_cnt_q + XLEN'(redir.mispredict);
  end

  sat_counter2 u_sat_counter2 (
    .cnt_i      (cnt_q[idx_e]),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .load_i     (cnt_load),
    .load_val_i (CNT_INIT),
    .cnt_next_c (cnt_d)
  );

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      valid_q       <= '0;
      tag_q         <= '0;
      target_q      <= '0;
      cnt_q         <= {ENTRIES{2'(WNT)}};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= target_d;
        cnt_q[idx_e]    <= cnt_d;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchValidE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  branch_predict_ctrl #(.IDX_W(6), .CNT_INIT(2'b10)) dut (
    .CPU_CLK      (clk),
    .CPU_RST_N    (rst_n),
    .PCF          (PCF),
    .PredTakenF   (PredTakenF),
    .PredTargetF  (PredTargetF),
    .BranchValidE (BranchValidE),
    .PCE          (PCE),
    .BranchE      (BranchE),
    .BrTargetE    (BrTargetE),
    .PredTakenE   (PredTakenE),
    .PredTargetE  (PredTargetE),
    .MispredictE  (MispredictE),
    .RedirectPCE  (RedirectPCE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .BranchCnt    (BranchCnt),
    .MispredCnt   (MispredCnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one record per table slot, plain integer counter
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_target[64];
  int          m_cnt   [64];
  int unsigned m_bcnt, m_mcnt;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return int'(pc >> 8);
  endfunction

  function automatic logic mpred(input logic [31:0] pc);
    int i;
    i = midx(pc);
    return m_valid[i] && (m_tag[i] == mtag(pc)) && (m_cnt[i] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_cnt[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endtask

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        misp;
    logic [31:0] rpc;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb_q[$];

  bit          have_prev = 1'b0;
  logic        prev_bv, prev_be, prev_misp;
  logic [31:0] prev_pce, prev_bt;

  task automatic model_train();
    int i;
    bit hit;
    if (!have_prev || !prev_bv) return;
    m_bcnt++;
    if (prev_misp) m_mcnt++;
    i   = midx(prev_pce);
    hit = m_valid[i] && (m_tag[i] == mtag(prev_pce));
    if (hit && prev_be) begin
      m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      m_target[i] = prev_bt;
    end else if (hit) begin
      m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end else if (prev_be) begin
      m_valid[i] = 1'b1; m_tag[i] = mtag(prev_pce); m_target[i] = prev_bt; m_cnt[i] = 2;
    end
  endtask

  // One pipeline cycle: retire last cycle's training, drive new inputs, push expectation
  task automatic cycle(input logic bv, input logic [31:0] pcf, input logic [31:0] pce,
                       input logic be, input logic [31:0] bt, input logic pte,
                       input logic [31:0] ptgt, input bit use_pred);
    exp_t e;
    int   i;
    @(posedge clk);
    #1;
    model_train();
    if (use_pred) begin
      pte  = mpred(pce);
      ptgt = m_target[midx(pce)];
    end
    BranchValidE = bv;
    PCF          = pcf;
    PCE          = pce;
    BranchE      = bv ? be : 1'bx;
    BrTargetE    = bv ? bt : 32'hxxxx_xxxx;
    PredTakenE   = pte;
    PredTargetE  = ptgt;
    i      = midx(pcf);
    e.pt   = mpred(pcf);
    e.ptgt = m_target[i];
    e.misp = bv && ((be != pte) || (be && pte && (ptgt != bt)));
    e.rpc  = be ? bt : pce + 32'd4;
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    sb_q.push_back(e);
    have_prev = 1'b1; prev_bv = bv; prev_pce = pce; prev_be = be; prev_bt = bt;
    prev_misp = e.misp;
  endtask

  task automatic idle(input logic [31:0] pcf);
    cycle(1'b0, pcf, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_PredTakenF", 32'(PredTakenF), 32'(e.pt));
      if (e.pt) chk("sb_PredTargetF", PredTargetF, e.ptgt);
      chk("sb_MispredictE", 32'(MispredictE), 32'(e.misp));
      chk("sb_FlushD", 32'(FlushD), 32'(e.misp));
      chk("sb_FlushE", 32'(FlushE), 32'(e.misp));
      if (e.misp) chk("sb_RedirectPCE", RedirectPCE, e.rpc);
      chk("sb_BranchCnt", BranchCnt, e.bcnt);
      chk("sb_MispredCnt", MispredCnt, e.mcnt);
    end
  end

  // Mid-cycle reset: outputs must clear without a clock edge
  task automatic do_reset(input logic [31:0] pcf);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    BranchValidE = 1'b0;
    PCF = pcf;
    #1;
    chk("rst_PredTakenF", 32'(PredTakenF), 32'h0);
    chk("rst_BranchCnt", BranchCnt, 32'h0);
    chk("rst_MispredCnt", MispredCnt, 32'h0);
    chk("rst_MispredictE", 32'(MispredictE), 32'h0);
    model_reset();
    have_prev = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0: return 32'h100;
      1: return 32'h104;
      2: return 32'h200;
      3: return 32'h300;
      4: return 32'h1100;
      5: return 32'h108;
      6: return 32'h204;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h80;
      1: return 32'h90;
      2: return 32'h400;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    BranchValidE = 1'b0; PCF = 32'h100; PCE = '0; BranchE = 1'b0; BrTargetE = '0;
    PredTakenE = 1'b0; PredTargetE = '0;
    model_reset();
    #2;
    chk("init_PredTakenF", 32'(PredTakenF), 32'h0);
    chk("init_BranchCnt", BranchCnt, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Allocation on a taken miss
    idle(32'h100);
    #1 chk("t1_PredTakenF_cold", 32'(PredTakenF), 32'h0);
    cycle(1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    #1 chk("t1_MispredictE", 32'(MispredictE), 32'h1);
    chk("t1_FlushD", 32'(FlushD), 32'h1);
    chk("t1_RedirectPCE", RedirectPCE, 32'h80);
    idle(32'h100);
    #1 chk("t1_PredTakenF", 32'(PredTakenF), 32'h1);
    chk("t1_PredTargetF", PredTargetF, 32'h80);

    // Two not-taken resolutions: 10 -> 01 -> 00
    cycle(1'b1, 32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1 chk("t2_first_misp", 32'(MispredictE), 32'h1);
    chk("t2_RedirectPCE", RedirectPCE, 32'h104);
    cycle(1'b1, 32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1 chk("t2_second_misp", 32'(MispredictE), 32'h0);
    idle(32'h100);
    #1 chk("t2_PredTakenF", 32'(PredTakenF), 32'h0);

    // Saturation at 11, then one not-taken leaves it predicting taken
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(32'h100);
    #1 chk("t3_PredTakenF", 32'(PredTakenF), 32'h1);

    // Aliasing: 0x200 shares the slot and retags it
    cycle(1'b1, 32'h100, 32'h200, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    idle(32'h100);
    #1 chk("t4_PredTakenF_old", 32'(PredTakenF), 32'h0);
    idle(32'h200);
    #1 chk("t4_PredTakenF_new", 32'(PredTakenF), 32'h1);

    // Target mismatch on a correctly predicted taken branch
    cycle(1'b1, 32'h200, 32'h200, 1'b1, 32'h90, 1'b1, 32'h80, 1'b0);
    #1 chk("t5_MispredictE", 32'(MispredictE), 32'h1);
    chk("t5_RedirectPCE", RedirectPCE, 32'h90);
    idle(32'h200);
    #1 chk("t5_PredTargetF", PredTargetF, 32'h90);

    // Statistics from a clean reset: 10 resolutions, 3 mispredicts
    do_reset(32'h200);
    for (int k = 0; k < 10; k++)
      cycle(1'b1, 32'h0, 32'h400 + 32'(4 * k), (k < 3), 32'h800, 1'b0, 32'h0, 1'b0);
    idle(32'h400);
    #1 chk("t6_BranchCnt", BranchCnt, 32'd10);
    chk("t6_MispredCnt", MispredCnt, 32'd3);
    chk("t6_PredTakenF", 32'(PredTakenF), 32'h1);
    for (int k = 0; k < 3; k++) idle(32'h400);
    #1 chk("t6_idle_BranchCnt", BranchCnt, 32'd10);
    do_reset(32'h400);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 400; n++) begin
      logic        bv, be, pte;
      logic [31:0] pcf, pce, bt, ptgt;
      bit          usep;
      pcf  = pick_pc();
      pce  = pick_pc();
      bv   = ($urandom_range(0, 9) < 7);
      be   = 1'($urandom_range(0, 1));
      bt   = pick_tgt();
      pte  = 1'($urandom_range(0, 1));
      ptgt = pick_tgt();
      usep = ($urandom_range(0, 3) != 0);
      cycle(bv, pcf, pce, be, bt, pte, ptgt, usep);
      if (n == 250) do_reset(pick_pc());
    end

    idle(32'h0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
